dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 Parameter ADDR_W, default 5, SHALL set the data-RAM word-address width.
REQ-003 req_valid input 1: CPU memory request present.
REQ-004 req_ready output 1: request accepted when req_valid && req_ready.
REQ-005 req_we input 1: 1 = store, 0 = load.
REQ-006 req_size input 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-007 req_signed input 1: sign-extend sub-word loads.
REQ-008 req_addr input 32: byte address.
REQ-009 req_wdata input 32: store data, right-aligned.
REQ-010 resp_valid output 1: one-cycle completion pulse.
REQ-011 resp_rdata output 32: load result, valid with resp_valid.
REQ-012 resp_err output 1: misaligned or unsupported request, valid with resp_valid.
REQ-013 ram_ena output 1, ram_wena output 1, ram_addr output ADDR_W, ram_wdata output 32: data-RAM drive.
REQ-014 ram_rdata input 32: combinational RAM read data, meaningful only while ram_ena=1.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, RMW_WR, RESP; req_ready=1 only in IDLE.
REQ-016 On acceptance, the block SHALL register the request and go to ACCESS; misaligned or reserved-size requests go to RESP with resp_err=1 and no RAM access.
REQ-017 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-018 ram_addr SHALL be addr[ADDR_W+1:2]; addr[31:ADDR_W+2] is ignored.
REQ-019 Byte lanes SHALL be little-endian: byte k at bits 8k+7:8k.
REQ-020 ACCESS, load or word store: ram_ena=1, ram_wena=req_we, ram_wdata=req_wdata; load data is extracted, extended, registered; next state RESP.
REQ-021 ACCESS, sub-word store: ram_ena=1, ram_wena=0, old word registered; next state RMW_WR.
REQ-022 RMW_WR: ram_ena=1, ram_wena=1, ram_wdata = old word with only the addressed lane(s) replaced; next state RESP.
REQ-023 RESP: resp_valid=1 for exactly one cycle; then IDLE.
REQ-024 Latency from acceptance cycle T: error resp T+1, load and word store T+2, sub-word store T+3.
REQ-025 Outside ACCESS/RMW_WR, ram_ena and ram_wena SHALL be 0.
REQ-026 Sub-word loads: zero-extend when req_signed=0, sign-extend when 1; store responses return resp_rdata=0.
REQ-027 resp_valid has no backpressure; req_valid while busy is ignored and must be held by the requester.

Reset
REQ-028 rst SHALL force IDLE, req_ready=1 from the following cycle; resp_valid, resp_err, resp_rdata, ram_ena, ram_wena = 0; ram_addr, ram_wdata = 0.
REQ-029 rst asserted in ACCESS or RMW_WR SHALL suppress any pending RAM write and the response.

Configuration
REQ-030 With DMEM_CTRL_SUBWORD_EN defined, byte/half requests SHALL behave per REQ-016..026.
REQ-031 Without it, RMW_WR SHALL be absent, and size 0/1 requests SHALL respond at T+1 with resp_err=1 and no RAM access.

Structure
REQ-032 Shared package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-033 Combinational lane extract/merge/extend SHALL live in sub-module dmem_lane.

Verification
REQ-034 Word store then load: store 0xDEADBEEF at addr 0x10. Then load word at 0x10 -> resp_rdata=0xDEADBEEF at T+2; RAM word 4 written once.
REQ-035 Byte RMW: word 4=0x11223344; store byte 0xAB at 0x12 -> word 4=0x11AB3344 at T+3. Then signed byte load at 0x12 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-036 Half-word: store half 0x8001 at 0x22 -> word 8 upper half 0x8001. Then signed half load at 0x22 -> 0xFFFF8001.
REQ-037 Misaligned and reserved: word load at 0x13 -> resp_err=1 at T+1, ram_ena never 1; size=3 -> same.
REQ-038 Reset mid-RMW: assert rst in RMW_WR cycle of a byte store -> RAM word unchanged, no resp_valid, req_ready=1 next cycle.
REQ-039 Busy and build option: req_valid held during ACCESS -> not accepted until IDLE. Build without DMEM_CTRL_SUBWORD_EN -> byte store gives resp_err=1 at T+1 and no RAM write.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access-size encodings,
// FSM state type, registered request payload and the request legality check.
// Build option: DMEM_CTRL_SUBWORD_EN enables byte/half accesses; without it
// the RMW_WR state does not exist and sub-word requests are rejected.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

`ifdef DMEM_CTRL_SUBWORD_EN
  localparam bit SUBWORD_EN = 1'b1;
  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_e;
`else
  localparam bit SUBWORD_EN = 1'b0;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
`endif

  // Request fields kept for the duration of one transaction.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
  } req_t;

  // Misaligned, reserved or (when disabled) sub-word requests are errors.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: req_bad = !SUBWORD_EN;
      SZ_HALF: req_bad = off[0] || !SUBWORD_EN;
      SZ_WORD: req_bad = (off != 2'd0);
      default: req_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// CPU request/response and data-RAM signals of the data-memory controller.
// master: requester plus RAM model side (drives req_*, ram_rdata).
// slave : dmem_ctrl side (drives req_ready, resp_*, ram_* controls).
interface dmem_ctrl_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              ram_ena;
  logic              ram_wena;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_ena, ram_wena, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_ena, ram_wena, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dmem_lane.sv
// Little-endian byte-lane logic: extracts and extends a load from a RAM word,
// and merges store data into the addressed lane(s) of an old word.
// Ports: size/off/sgn describe the access; word is the RAM word; wdata is
// right-aligned store data; rdata_c is the load result; merged_c the new word.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic              sgn,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c,
  output logic [DATA_W-1:0] merged_c
);

  logic [15:0]       lo;
  logic [DATA_W-1:0] wdata_sh;
  logic [3:0]        lane_mask;

  // Shift the addressed lane down for loads, store data up for merges.
  always_comb begin
    lo        = 16'(word >> {off, 3'b000});
    wdata_sh  = wdata << {off, 3'b000};
    rdata_c   = word;
    lane_mask = 4'b1111;
    merged_c  = word;
    case (size)
      SZ_BYTE: begin
        rdata_c   = {{24{sgn & lo[7]}}, lo[7:0]};
        lane_mask = 4'b0001 << off;
      end
      SZ_HALF: begin
        rdata_c   = {{16{sgn & lo[15]}}, lo[15:0]};
        lane_mask = 4'b0011 << off;
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged_c[8*i +: 8] = lane_mask[i] ? wdata_sh[8*i +: 8] : word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one CPU load/store at a time, drives a
// single-port data RAM with combinational read data, and returns a one-cycle
// response. Sub-word stores use read-modify-write.
// Ports: clk, rst (sync, active high), bus (dmem_ctrl_if.slave) carrying the
// request/response handshake and the RAM drive.
// Build option: define DMEM_CTRL_SUBWORD_EN to support byte/half accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ena_q, ena_d;
  logic              wena_q, wena_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              bad_c;
  logic [DATA_W-1:0] lane_rdata_c, lane_merged_c;
  logic              unused_c;

  assign bad_c = req_bad(bus.req_size, bus.req_addr[1:0]);

  // Upper address bits beyond the RAM are deliberately ignored.
  assign unused_c = ^{bus.req_addr[31:ADDR_W+2], lane_merged_c};

  dmem_lane u_lane (
    .size     (req_q.size),
    .off      (req_q.off),
    .sgn      (req_q.sgn),
    .word     (bus.ram_rdata),
    .wdata    (wdata_q),
    .rdata_c  (lane_rdata_c),
    .merged_c (lane_merged_c)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ena_d   = 1'b0;
    wena_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d   = '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed,
                      off: bus.req_addr[1:0]};
          addr_d  = bus.req_addr[ADDR_W+1:2];
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = bad_c;
          if (bad_c) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            ena_d   = 1'b1;
            wena_d  = bus.req_we && (bus.req_size == SZ_WORD);
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!req_q.we) rdata_d = lane_rdata_c;
`ifdef DMEM_CTRL_SUBWORD_EN
        // Sub-word store: the old word is on ram_rdata now; write back merged.
        if (req_q.we && (req_q.size != SZ_WORD)) begin
          state_d = RMW_WR;
          ena_d   = 1'b1;
          wena_d  = 1'b1;
          wdata_d = lane_merged_c;
        end
`endif
      end
`ifdef DMEM_CTRL_SUBWORD_EN
      RMW_WR: state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d      = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      ena_q        <= 1'b0;
      wena_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      ena_q        <= ena_d;
      wena_q       <= wena_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.ram_ena    = ena_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_wdata  = wdata_q;
  // rst gates the write strobe directly so a write in flight when reset is
  // sampled never reaches the RAM.
  assign bus.ram_wena   = wena_q & ~rst;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus random requests
// checked against a word-array reference model of the memory.
module tb_dmem_ctrl;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;
`ifdef DMEM_CTRL_SUBWORD_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  dmem_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  bit [31:0] ram     [DEPTH];
  bit [31:0] ref_mem [DEPTH];
  int ena_cnt  = 0;
  int wr_cnt   = 0;
  int resp_cnt = 0;
  int tests    = 0;
  int fails    = 0;

  // RAM with combinational read and a write port sampled on the clock.
  assign bus.ram_rdata = ram[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_ena === 1'b1) ena_cnt <= ena_cnt + 1;
    if (bus.resp_valid === 1'b1) resp_cnt <= resp_cnt + 1;
    if (bus.ram_ena === 1'b1 && bus.ram_wena === 1'b1) begin
      ram[bus.ram_addr] <= bus.ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: outcome of one request from the access rules, updating ref_mem.
  task automatic model(input bit we, input bit [1:0] size, input bit sgn,
                       input bit [31:0] addr, input bit [31:0] wdata,
                       output bit err, output int lat, output bit [31:0] rdata,
                       output int enas, output int writes);
    int idx;
    int off;
    int nb;
    longint unsigned mask;
    longint unsigned val;
    idx    = int'(addr[ADDR_W+1:2]);
    off    = int'(addr[1:0]);
    nb     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err    = (size == 2'd3) || (off % nb != 0) || (!SUB_EN && nb < 4);
    rdata  = 32'd0;
    enas   = 0;
    writes = 0;
    lat    = 1;
    if (err) return;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    if (!we) begin
      val = (64'(ref_mem[idx]) >> (8 * off)) & mask;
      if (sgn && nb < 4 && val > (mask >> 1)) val = val + (64'hFFFF_FFFF - mask);
      rdata = val[31:0];
      lat   = 2;
      enas  = 1;
    end else begin
      val = 64'(ref_mem[idx]);
      val = (val & ~(mask << (8 * off))) | ((64'(wdata) & mask) << (8 * off));
      ref_mem[idx] = val[31:0];
      writes = 1;
      lat    = (nb == 4) ? 2 : 3;
      enas   = (nb == 4) ? 1 : 2;
    end
  endtask

  // Issue one request (called at a negedge) and check the full transaction.
  task automatic do_req(input string tag, input bit we, input bit [1:0] size,
                        input bit sgn, input bit [31:0] addr, input bit [31:0] wdata,
                        input bit hold);
    bit        e_err;
    int        e_lat, e_ena, e_wr, lat, waited, ena0, wr0, idx;
    bit [31:0] e_rd;
    model(we, size, sgn, addr, wdata, e_err, e_lat, e_rd, e_ena, e_wr);
    idx            = int'(addr[ADDR_W+1:2]);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("%s accept", tag), 32'(bus.req_ready), 32'd1);
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
      return;
    end
    ena0 = ena_cnt;
    wr0  = wr_cnt;
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 8) begin
      chk($sformatf("%s busy", tag), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s latency", tag), 32'(lat), 32'(e_lat));
    chk($sformatf("%s err", tag), 32'(bus.resp_err), 32'(e_err));
    chk($sformatf("%s rdata", tag), bus.resp_rdata, e_rd);
    chk($sformatf("%s ready@resp", tag), 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk($sformatf("%s pulse", tag), 32'(bus.resp_valid), 32'd0);
    chk($sformatf("%s idle", tag), 32'(bus.req_ready), 32'd1);
    chk($sformatf("%s ram_ena cycles", tag), 32'(ena_cnt - ena0), 32'(e_ena));
    chk($sformatf("%s ram writes", tag), 32'(wr_cnt - wr0), 32'(e_wr));
    chk($sformatf("%s ram word", tag), ram[idx], ref_mem[idx]);
  endtask

  initial begin
    int ena0;
    int wr0;
    int resp0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst ram_ena", 32'(bus.ram_ena), 32'd0);
    chk("rst ram_wena", 32'(bus.ram_wena), 32'd0);
    chk("rst ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst ram_wdata", bus.ram_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store then load.
    do_req("st_w10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    do_req("ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);

    // Byte read-modify-write and byte loads.
    do_req("st_w10b", 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 1'b0);
    do_req("st_b12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AB, 1'b0);
    do_req("ld_sb12", 1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b0);
    do_req("ld_ub12", 1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 1'b0);

    // Half-word store and signed/unsigned loads.
    do_req("st_h22", 1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF_8001, 1'b0);
    do_req("ld_sh22", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b0);
    do_req("ld_uh22", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b0);

    // Misaligned and reserved-size requests.
    do_req("ld_w13", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 1'b0);
    do_req("ld_rsvd", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0);
    do_req("st_h21", 1'b1, 2'd1, 1'b0, 32'h21, 32'h1234, 1'b0);

    // Upper address bits are ignored.
    do_req("ld_hi", 1'b0, 2'd2, 1'b0, 32'hFFFF_FF10, 32'h0, 1'b0);

    // Request held through a busy transaction is taken again only from IDLE.
    do_req("hold1", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    do_req("hold2", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);

    // Reset while a write is about to reach the RAM.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_signed = 1'b0;
    bus.req_wdata  = 32'hCAFE_F00D;
`ifdef DMEM_CTRL_SUBWORD_EN
    bus.req_size   = 2'd0;
    bus.req_addr   = 32'h15;
`else
    bus.req_size   = 2'd2;
    bus.req_addr   = 32'h14;
`endif
    chk("rstw ready", 32'(bus.req_ready), 32'd1);
    ena0  = ena_cnt;
    wr0   = wr_cnt;
    resp0 = resp_cnt;
    @(negedge clk);
    bus.req_valid = 1'b0;
`ifdef DMEM_CTRL_SUBWORD_EN
    @(negedge clk);
`endif
    chk("rstw ram_ena", 32'(bus.ram_ena), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw ram_wena", 32'(bus.ram_wena), 32'd0);
    @(negedge clk);
    chk("rstw req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstw ram_ena off", 32'(bus.ram_ena), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstw no resp", 32'(resp_cnt - resp0), 32'd0);
    chk("rstw no write", 32'(wr_cnt - wr0), 32'd0);
    chk("rstw ena cycles", 32'(ena_cnt - ena0), SUB_EN ? 32'd2 : 32'd1);
    chk("rstw word", ram[5], ref_mem[5]);

    // Random traffic, mostly aligned.
    for (int i = 0; i < 60; i++) begin
      bit [1:0]  sz;
      bit [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd1) ? {a[1], 1'b0} : 2'b00;
      do_req($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), sz,
             1'($urandom_range(0, 1)), a, $urandom(), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
